// File: rtl/pair_unswapper.sv
// rtl/pair_unswapper.sv - restores original operand order of sorted pairs through a small FIFO
`timescale 1ns/1ps
module pair_unswapper #(
  parameter int width = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] largest,
  input  logic [width-1:0] smallest,
  input  logic             swapped,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] a_out,
  output logic [width-1:0] b_out,
  output logic             order_err,
  output logic [CNT_W-1:0] pair_cnt
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [width-1:0] mem_a_q [DEPTH];
  logic [width-1:0] mem_b_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             order_err_q;
  logic [CNT_W-1:0] pair_cnt_q;

  logic             full, empty, push, pop, illegal;
  logic [width-1:0] dec_a, dec_b;

  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  // Ready comes only from the occupancy register; held low while reset is applied.
  assign in_ready  = ~rst & ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Undo the compare-stage routing before storage, and flag pairs the compare stage could not produce.
  always_comb begin
    dec_a   = swapped ? smallest : largest;
    dec_b   = swapped ? largest  : smallest;
    illegal = (largest < smallest) | (swapped & (largest == smallest));
  end

  // Occupancy next state: unchanged on simultaneous push and pop.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array; contents are only observed through the valid head, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= dec_a;
      mem_b_q[wr_ptr_q] <= dec_b;
    end
  end

  // Pointers, occupancy, sticky error flag and delivered-pair counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      order_err_q <= 1'b0;
      pair_cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (illegal) order_err_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        pair_cnt_q <= pair_cnt_q + CNT_W'(1);
      end
    end
  end

  // Head entry is forced to zero while empty so stale storage never shows.
  assign a_out     = out_valid ? mem_a_q[rd_ptr_q] : '0;
  assign b_out     = out_valid ? mem_b_q[rd_ptr_q] : '0;
  assign order_err = order_err_q;
  assign pair_cnt  = pair_cnt_q;

endmodule

// File: tb/tb_pair_unswapper.sv
// tb/tb_pair_unswapper.sv - directed self-checking bench for pair_unswapper
`timescale 1ns/1ps
module tb_pair_unswapper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  largest = 8'h00;
  logic [7:0]  smallest = 8'h00;
  logic        swapped = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  a_out, b_out;
  logic        order_err;
  logic [15:0] pair_cnt;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  typedef struct { logic [7:0] a; logic [7:0] b; } pair_t;
  pair_t exp_q[$];

  pair_unswapper #(.width(8), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .largest(largest), .smallest(smallest), .swapped(swapped),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out),
    .order_err(order_err), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    exp_cnt = 0;
  endtask

  task automatic test_reset;
    #2;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (a_out !== 8'h00 || b_out !== 8'h00) begin bad++; $display("FAIL rst_data got=%h/%h want=00/00", a_out, b_out); end
    total++; if (order_err !== 1'b0) begin bad++; $display("FAIL rst_order_err got=%b want=0", order_err); end
    total++; if (pair_cnt !== 16'h0000) begin bad++; $display("FAIL rst_pair_cnt got=%h want=0000", pair_cnt); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_no_swap;
    out_ready = 1'b1;
    in_valid = 1'b1; largest = 8'h90; smallest = 8'h12; swapped = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL noswap_no_bypass got=%b want=0", out_valid); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL noswap_valid got=%b want=1", out_valid); end
    total++; if (a_out !== 8'h90 || b_out !== 8'h12) begin bad++; $display("FAIL noswap_data got=%h/%h want=90/12", a_out, b_out); end
    tick();
    exp_cnt++;
    total++; if (pair_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL noswap_cnt got=%0d want=%0d", pair_cnt, exp_cnt); end
    total++; if (order_err !== 1'b0) begin bad++; $display("FAIL noswap_err got=%b want=0", order_err); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL noswap_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_swap;
    out_ready = 1'b1;
    in_valid = 1'b1; largest = 8'h7F; smallest = 8'h03; swapped = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (a_out !== 8'h03 || b_out !== 8'h7F || out_valid !== 1'b1) begin bad++; $display("FAIL swap_data got=%h/%h v=%b want=03/7f v=1", a_out, b_out, out_valid); end
    tick();
    exp_cnt++;
    total++; if (pair_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL swap_cnt got=%0d want=%0d", pair_cnt, exp_cnt); end
  endtask

  task automatic test_fill;
    out_ready = 1'b0;
    in_valid = 1'b1; largest = 8'hA1; smallest = 8'h11; swapped = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready1 got=%b want=1", in_ready); end
    largest = 8'hB2; smallest = 8'h22; swapped = 1'b1;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%b want=0", in_ready); end
    largest = 8'hC3; smallest = 8'h33; swapped = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || a_out !== 8'hA1 || b_out !== 8'h11) begin bad++; $display("FAIL fill_hold got=r%b %h/%h want=r0 a1/11", in_ready, a_out, b_out); end
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_after_pop got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b1 || a_out !== 8'h22 || b_out !== 8'hB2) begin bad++; $display("FAIL fill_second got=v%b %h/%h want=v1 22/b2", out_valid, a_out, b_out); end
    tick();
    exp_cnt++;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_third_dropped got=%b want=0", out_valid); end
    total++; if (pair_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL fill_cnt got=%0d want=%0d", pair_cnt, exp_cnt); end
  endtask

  task automatic test_stream;
    logic [7:0] x, y, l, s;
    logic sw;
    pair_t p;
    int popped = 0;
    int guard = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      l = (x >= y) ? x : y;
      s = (x >= y) ? y : x;
      sw = (l != s) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_valid = 1'b1; largest = l; smallest = s; swapped = sw;
      if (out_valid === 1'b1) begin
        p = exp_q.pop_front();
        total++; if (a_out !== p.a || b_out !== p.b) begin bad++; $display("FAIL stream_data i=%0d got=%h/%h want=%h/%h", i, a_out, b_out, p.a, p.b); end
        exp_cnt++;
        popped++;
      end else if (i > 0) begin
        total++; bad++; $display("FAIL stream_valid i=%0d got=0 want=1", i);
      end
      tick();
      p.a = sw ? s : l;
      p.b = sw ? l : s;
      exp_q.push_back(p);
    end
    in_valid = 1'b0;
    while (exp_q.size() > 0 && guard < 10) begin
      if (out_valid === 1'b1) begin
        p = exp_q.pop_front();
        total++; if (a_out !== p.a || b_out !== p.b) begin bad++; $display("FAIL stream_drain got=%h/%h want=%h/%h", a_out, b_out, p.a, p.b); end
        exp_cnt++;
        popped++;
      end
      tick();
      guard++;
    end
    total++; if (popped != 100) begin bad++; $display("FAIL stream_count got=%0d want=100", popped); end
    total++; if (pair_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL stream_cnt got=%0d want=%0d", pair_cnt, exp_cnt); end
    total++; if (order_err !== 1'b0) begin bad++; $display("FAIL stream_err got=%b want=0", order_err); end
    exp_q.delete();
  endtask

  task automatic test_illegal;
    out_ready = 1'b0;
    in_valid = 1'b1; largest = 8'h05; smallest = 8'h09; swapped = 1'b0;
    total++; if (order_err !== 1'b0) begin bad++; $display("FAIL ill_pre got=%b want=0", order_err); end
    tick();
    in_valid = 1'b0;
    total++; if (order_err !== 1'b1) begin bad++; $display("FAIL ill_lt_err got=%b want=1", order_err); end
    total++; if (out_valid !== 1'b1 || a_out !== 8'h05 || b_out !== 8'h09) begin bad++; $display("FAIL ill_lt_data got=v%b %h/%h want=v1 05/09", out_valid, a_out, b_out); end
    out_ready = 1'b1;
    tick();
    do_reset();
    total++; if (order_err !== 1'b0) begin bad++; $display("FAIL ill_tie_pre got=%b want=0", order_err); end
    in_valid = 1'b1; largest = 8'h44; smallest = 8'h44; swapped = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (order_err !== 1'b1) begin bad++; $display("FAIL ill_tie_err got=%b want=1", order_err); end
    total++; if (a_out !== 8'h44 || b_out !== 8'h44) begin bad++; $display("FAIL ill_tie_data got=%h/%h want=44/44", a_out, b_out); end
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    in_valid = 1'b1; largest = 8'h90; smallest = 8'h12; swapped = 1'b0;
    tick();
    in_valid = 1'b0;
    total++; if (a_out !== 8'h90 || b_out !== 8'h12) begin bad++; $display("FAIL ill_legal_data got=%h/%h want=90/12", a_out, b_out); end
    tick();
    exp_cnt++;
    total++; if (order_err !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b want=1", order_err); end
    total++; if (pair_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL ill_cnt got=%0d want=%0d", pair_cnt, exp_cnt); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    in_valid = 1'b1; largest = 8'h0F; smallest = 8'h0E; swapped = 1'b0;
    tick();
    largest = 8'h3C; smallest = 8'h2B;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL arst_pre got=v%b r%b want=v1 r0", out_valid, in_ready); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", out_valid); end
    total++; if (order_err !== 1'b0 || pair_cnt !== 16'h0000) begin bad++; $display("FAIL arst_flags got=e%b c%h want=e0 c0000", order_err, pair_cnt); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL arst_ready got=%b want=0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_release_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    tick();
    tick();
    total++; if (out_valid !== 1'b0 || pair_cnt !== 16'h0000) begin bad++; $display("FAIL arst_stale got=v%b c%h want=v0 c0000", out_valid, pair_cnt); end
  endtask

  task automatic test_cnt_wrap;
    int pops = 0;
    int cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; largest = 8'h21; smallest = 8'h20; swapped = 1'b1;
    while (pops < 65535 && cyc < 70000) begin
      if (out_valid === 1'b1) pops++;
      tick();
      cyc++;
    end
    total++; if (pair_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_max got=%h want=ffff", pair_cnt); end
    total++; if (out_valid !== 1'b1 || a_out !== 8'h20 || b_out !== 8'h21) begin bad++; $display("FAIL wrap_head got=v%b %h/%h want=v1 20/21", out_valid, a_out, b_out); end
    tick();
    in_valid = 1'b0;
    total++; if (pair_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h want=0000", pair_cnt); end
    total++; if (order_err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b want=0", order_err); end
  endtask

  initial begin
    test_reset();
    test_no_swap();
    test_swap();
    test_fill();
    test_stream();
    test_illegal();
    test_async_reset();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
